// File: rtl/sync_fifo_bank_fwft.sv
// Bank of NUM_CH independent first-word-fall-through FIFOs.
// Per channel: flush, almost-full, sticky overflow/underflow flags.
module sync_fifo_bank_fwft #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int NUM_CH     = 4,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_CH-1:0]                   push,
   input  logic [NUM_CH*DATA_WIDTH-1:0]        push_data,
   input  logic [NUM_CH-1:0]                   pop,
   output logic [NUM_CH*DATA_WIDTH-1:0]        pop_data,
   output logic [NUM_CH-1:0]                   pop_data_valid,
   input  logic [NUM_CH-1:0]                   flush,
   input  logic                                err_clr,
   output logic [NUM_CH-1:0]                   empty,
   output logic [NUM_CH-1:0]                   full,
   output logic [NUM_CH-1:0]                   almost_full,
   output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]    count,
   output logic [NUM_CH-1:0]                   overflow_err,
   output logic [NUM_CH-1:0]                   underflow_err
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] LP_AF = PW'(AF_THRESH);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]         r_wptr;
      logic [PW-1:0]         r_rptr;
      logic                  r_ovf;
      logic                  r_udf;
      logic [PW-1:0]         w_count;
      logic                  w_empty;
      logic                  w_full;
      logic                  w_pop_acc;
      logic                  w_push_acc;
      logic                  w_ovf_set;
      logic                  w_udf_set;

      assign w_empty = (r_wptr == r_rptr);
      assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                       (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
      assign w_count = r_wptr - r_rptr;

      // A full channel still takes a push when the head leaves in the same cycle.
      assign w_pop_acc  = pop[g] && !w_empty && !flush[g];
      assign w_push_acc = push[g] && !flush[g] && (!w_full || w_pop_acc);
      assign w_ovf_set  = push[g] && !flush[g] && !w_push_acc;
      assign w_udf_set  = pop[g] && !flush[g] && w_empty;

      always_ff @(posedge clk) begin
         if (!rst && w_push_acc) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <=
               push_data[g*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      always_ff @(posedge clk) begin
         if (rst || flush[g]) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push_acc) r_wptr <= r_wptr + 1'b1;
            if (w_pop_acc)  r_rptr <= r_rptr + 1'b1;
         end
      end

      // Setting beats a simultaneous clear.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
         end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
            r_udf <= w_udf_set | (r_udf & ~err_clr);
         end
      end

      assign pop_data[g*DATA_WIDTH +: DATA_WIDTH] =
         r_mem[r_rptr[ADDR_WIDTH-1:0]];
      assign pop_data_valid[g]      = !w_empty;
      assign empty[g]               = w_empty;
      assign full[g]                = w_full;
      assign almost_full[g]         = (w_count >= LP_AF);
      assign count[g*PW +: PW]      = w_count;
      assign overflow_err[g]        = r_ovf;
      assign underflow_err[g]       = r_udf;
   end

endmodule

// File: tb/tb_sync_fifo_bank_fwft.sv
// Bench for sync_fifo_bank_fwft: vector table plus queue scoreboard.
// Configuration: 8-bit data, depth 4, two channels, almost-full at 3.
module tb_sync_fifo_bank_fwft;

   localparam int DW  = 8;
   localparam int DEP = 4;
   localparam int NC  = 2;
   localparam int AFT = 3;
   localparam int PW  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC-1:0]     push;
   logic [NC*DW-1:0]  push_data;
   logic [NC-1:0]     pop;
   logic [NC*DW-1:0]  pop_data;
   logic [NC-1:0]     pop_data_valid;
   logic [NC-1:0]     flush;
   logic              err_clr;
   logic [NC-1:0]     empty;
   logic [NC-1:0]     full;
   logic [NC-1:0]     almost_full;
   logic [NC*PW-1:0]  count;
   logic [NC-1:0]     overflow_err;
   logic [NC-1:0]     underflow_err;

   always #5 clk = ~clk;

   sync_fifo_bank_fwft #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEP),
      .NUM_CH    (NC),
      .AF_THRESH (AFT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .push          (push),
      .push_data     (push_data),
      .pop           (pop),
      .pop_data      (pop_data),
      .pop_data_valid(pop_data_valid),
      .flush         (flush),
      .err_clr       (err_clr),
      .empty         (empty),
      .full          (full),
      .almost_full   (almost_full),
      .count         (count),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   typedef struct {
      logic [1:0] pu;
      logic [1:0] po;
      logic [1:0] fl;
      logic       clr;
      logic [7:0] d0;
      logic [7:0] d1;
      int         c0;
      int         c1;
      logic [1:0] ovf;
      logic [1:0] udf;
   } vec_t;

   int         n_run  = 0;
   int         n_fail = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [1:0] m_ovf;
   logic [1:0] m_udf;
   vec_t       tbl[23];

   function automatic vec_t mk(logic [1:0] pu, logic [1:0] po,
                               logic [1:0] fl, logic clr,
                               logic [7:0] d0, logic [7:0] d1,
                               int c0, int c1,
                               logic [1:0] ovf, logic [1:0] udf);
      vec_t v;
      v.pu = pu; v.po = po; v.fl = fl; v.clr = clr;
      v.d0 = d0; v.d1 = d1; v.c0 = c0; v.c1 = c1;
      v.ovf = ovf; v.udf = udf;
      return v;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int qsize(int c);
      return (c == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [7:0] qhead(int c);
      return (c == 0) ? q0[0] : q1[0];
   endfunction

   task automatic check_state(int c0, int c1, logic [1:0] ov, logic [1:0] ud);
      int e;
      for (int c = 0; c < NC; c++) begin
         e = (c == 0) ? c0 : c1;
         chk($sformatf("count%0d", c), int'(count[c*PW +: PW]), e);
         chk($sformatf("empty%0d", c), int'(empty[c]), int'(e == 0));
         chk($sformatf("full%0d", c), int'(full[c]), int'(e == DEP));
         chk($sformatf("af%0d", c), int'(almost_full[c]), int'(e >= AFT));
         chk($sformatf("valid%0d", c), int'(pop_data_valid[c]), int'(e != 0));
      end
      chk("ovf", int'(overflow_err), int'(ov));
      chk("udf", int'(underflow_err), int'(ud));
   endtask

   // Drive one cycle; the reference queues decide what is accepted.
   task automatic apply(logic [1:0] pu, logic [1:0] po, logic [1:0] fl,
                        logic clr, logic [7:0] d0, logic [7:0] d1);
      logic [1:0] ovs;
      logic [1:0] uds;
      logic       pa;
      logic       pacc;
      int         sz;
      push = pu; pop = po; flush = fl; err_clr = clr;
      push_data = {d1, d0};
      #1;
      ovs = '0;
      uds = '0;
      for (int c = 0; c < NC; c++) begin
         sz = qsize(c);
         if (fl[c]) begin
            if (c == 0) q0.delete(); else q1.delete();
         end else begin
            pa   = po[c] && (sz > 0);
            pacc = pu[c] && ((sz < DEP) || pa);
            if (po[c] && sz == 0) uds[c] = 1'b1;
            if (pu[c] && !pacc)   ovs[c] = 1'b1;
            if (pa) begin
               chk($sformatf("pop_data%0d", c),
                   int'(pop_data[c*DW +: DW]), int'(qhead(c)));
               if (c == 0) void'(q0.pop_front());
               else        void'(q1.pop_front());
            end
            if (pacc) begin
               if (c == 0) q0.push_back(d0); else q1.push_back(d1);
            end
         end
      end
      m_ovf = ovs | (m_ovf & ~{NC{clr}});
      m_udf = uds | (m_udf & ~{NC{clr}});
      @(posedge clk);
      #1;
      push = '0; pop = '0; flush = '0; err_clr = 1'b0;
      for (int c = 0; c < NC; c++) begin
         if (qsize(c) > 0)
            chk($sformatf("head%0d", c),
                int'(pop_data[c*DW +: DW]), int'(qhead(c)));
      end
   endtask

   initial begin
      tbl[0]  = mk(2'b01, 2'b00, 2'b00, 0, 8'h11, 8'h00, 1, 0, 2'b00, 2'b00);
      tbl[1]  = mk(2'b01, 2'b00, 2'b00, 0, 8'h22, 8'h00, 2, 0, 2'b00, 2'b00);
      tbl[2]  = mk(2'b01, 2'b00, 2'b00, 0, 8'h33, 8'h00, 3, 0, 2'b00, 2'b00);
      tbl[3]  = mk(2'b01, 2'b00, 2'b00, 0, 8'h44, 8'h00, 4, 0, 2'b00, 2'b00);
      tbl[4]  = mk(2'b01, 2'b01, 2'b00, 0, 8'h55, 8'h00, 4, 0, 2'b00, 2'b00);
      tbl[5]  = mk(2'b00, 2'b01, 2'b00, 0, 8'h00, 8'h00, 3, 0, 2'b00, 2'b00);
      tbl[6]  = mk(2'b00, 2'b01, 2'b00, 0, 8'h00, 8'h00, 2, 0, 2'b00, 2'b00);
      tbl[7]  = mk(2'b00, 2'b01, 2'b00, 0, 8'h00, 8'h00, 1, 0, 2'b00, 2'b00);
      tbl[8]  = mk(2'b00, 2'b01, 2'b00, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00);
      tbl[9]  = mk(2'b01, 2'b00, 2'b00, 0, 8'h61, 8'h00, 1, 0, 2'b00, 2'b00);
      tbl[10] = mk(2'b01, 2'b00, 2'b00, 0, 8'h62, 8'h00, 2, 0, 2'b00, 2'b00);
      tbl[11] = mk(2'b01, 2'b00, 2'b00, 0, 8'h63, 8'h00, 3, 0, 2'b00, 2'b00);
      tbl[12] = mk(2'b01, 2'b00, 2'b00, 0, 8'h64, 8'h00, 4, 0, 2'b00, 2'b00);
      tbl[13] = mk(2'b01, 2'b00, 2'b00, 0, 8'h65, 8'h00, 4, 0, 2'b01, 2'b00);
      tbl[14] = mk(2'b00, 2'b10, 2'b00, 0, 8'h00, 8'h00, 4, 0, 2'b01, 2'b10);
      tbl[15] = mk(2'b00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 4, 0, 2'b01, 2'b10);
      tbl[16] = mk(2'b00, 2'b10, 2'b00, 1, 8'h00, 8'h00, 4, 0, 2'b00, 2'b10);
      tbl[17] = mk(2'b00, 2'b00, 2'b00, 1, 8'h00, 8'h00, 4, 0, 2'b00, 2'b00);
      tbl[18] = mk(2'b10, 2'b01, 2'b00, 0, 8'h00, 8'h77, 3, 1, 2'b00, 2'b00);
      tbl[19] = mk(2'b01, 2'b01, 2'b01, 0, 8'h99, 8'h00, 0, 1, 2'b00, 2'b00);
      tbl[20] = mk(2'b00, 2'b10, 2'b00, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00);
      tbl[21] = mk(2'b01, 2'b01, 2'b00, 0, 8'h88, 8'h00, 1, 0, 2'b00, 2'b01);
      tbl[22] = mk(2'b00, 2'b01, 2'b00, 1, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00);

      rst = 1'b1;
      push = '0; pop = '0; flush = '0; err_clr = 1'b0; push_data = '0;
      m_ovf = '0; m_udf = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_state(0, 0, 2'b00, 2'b00);

      for (int i = 0; i < 23; i++) begin
         apply(tbl[i].pu, tbl[i].po, tbl[i].fl, tbl[i].clr,
               tbl[i].d0, tbl[i].d1);
         check_state(tbl[i].c0, tbl[i].c1, tbl[i].ovf, tbl[i].udf);
         chk("model_ovf", int'(overflow_err), int'(m_ovf));
      end

      // Streaming across pointer wrap on channel 1.
      apply(2'b10, 2'b00, 2'b00, 0, 8'h00, 8'h00);
      chk("wrap_start", int'(count[PW +: PW]), 1);
      for (int i = 1; i < 20; i++) begin
         apply(2'b10, 2'b10, 2'b00, 0, 8'h00, 8'(i));
         chk($sformatf("wrap_cnt%0d", i), int'(count[PW +: PW]), 1);
      end
      apply(2'b00, 2'b10, 2'b00, 0, 8'h00, 8'h00);
      chk("wrap_drained", qsize(1), 0);
      check_state(0, 0, 2'b00, 2'b00);

      // Reset in the middle of traffic.
      apply(2'b11, 2'b00, 2'b00, 0, 8'hA1, 8'hB1);
      apply(2'b11, 2'b00, 2'b00, 0, 8'hA2, 8'hB2);
      check_state(2, 2, 2'b00, 2'b00);
      rst = 1'b1;
      push = 2'b11; pop = 2'b11; push_data = 16'hC3C4;
      @(posedge clk);
      #1;
      rst = 1'b0;
      push = '0; pop = '0;
      q0.delete(); q1.delete();
      m_ovf = '0; m_udf = '0;
      check_state(0, 0, 2'b00, 2'b00);
      apply(2'b01, 2'b00, 2'b00, 0, 8'hAA, 8'h00);
      chk("rst_readback", int'(pop_data[7:0]), 8'hAA);
      check_state(1, 0, 2'b00, 2'b00);
      apply(2'b00, 2'b01, 2'b00, 0, 8'h00, 8'h00);
      check_state(0, 0, 2'b00, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
